// File: rtl/imem_loader.sv
// Loads a 256x32 instruction memory from an 8-bit valid/ready byte stream over Avalon-MM,
// holding the processor in reset, with an optional read-back checksum pass.
module imem_loader #(
   parameter int ADDR_W    = 8,
   parameter int NUM_WORDS = 256,
   parameter int VERIFY    = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W:0]   length,
   input  logic [7:0]        s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [ADDR_W+1:0] avm_address,
   output logic              avm_write,
   output logic              avm_read,
   output logic [31:0]       avm_writedata,
   output logic [3:0]        avm_byteenable,
   input  logic              avm_waitrequest,
   input  logic [31:0]       avm_readdata,
   input  logic              avm_readdatavalid,
   output logic              busy,
   output logic              cpu_hold,
   output logic              done,
   output logic [1:0]        error
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_COLLECT = 3'd1;
   localparam logic [2:0] S_WRITE   = 3'd2;
   localparam logic [2:0] S_RD_REQ  = 3'd3;
   localparam logic [2:0] S_RD_WAIT = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   localparam logic [1:0] ERR_OK  = 2'b00;
   localparam logic [1:0] ERR_LEN = 2'b01;
   localparam logic [1:0] ERR_SUM = 2'b10;

   localparam logic [ADDR_W:0] MAX_LEN = NUM_WORDS[ADDR_W:0];

   logic [2:0]      state;
   logic [ADDR_W:0] len;
   logic [ADDR_W:0] idx;
   logic [1:0]      bcnt;
   logic [31:0]     word;
   logic [31:0]     wsum;
   logic [31:0]     rsum;
   logic [31:0]     rsum_next;
   logic            last;
   logic            bad_len;

   assign last      = (idx == len - 1'b1);
   assign bad_len   = (length == '0) || (length > MAX_LEN);
   assign rsum_next = rsum + avm_readdata;

   // Strobes decode straight from state so an async reset drops them immediately.
   assign s_ready        = (state == S_COLLECT);
   assign avm_write      = (state == S_WRITE);
   assign avm_read       = (state == S_RD_REQ);
   assign avm_address    = {idx[ADDR_W-1:0], 2'b00};
   assign avm_writedata  = word;
   assign avm_byteenable = (avm_write || avm_read) ? 4'b1111 : 4'b0000;
   assign busy           = (state == S_COLLECT) || (state == S_WRITE) ||
                           (state == S_RD_REQ)  || (state == S_RD_WAIT);
   assign cpu_hold       = busy;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         len   <= '0;
         idx   <= '0;
         bcnt  <= '0;
         word  <= '0;
         wsum  <= '0;
         rsum  <= '0;
         done  <= 1'b0;
         error <= ERR_OK;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  len   <= length;
                  idx   <= '0;
                  bcnt  <= '0;
                  wsum  <= '0;
                  rsum  <= '0;
                  done  <= bad_len;
                  error <= bad_len ? ERR_LEN : ERR_OK;
                  state <= bad_len ? S_DONE : S_COLLECT;
               end
            end
            S_COLLECT: begin
               if (s_valid) begin
                  word[{bcnt, 3'b000} +: 8] <= s_data;
                  bcnt <= bcnt + 1'b1;
                  if (bcnt == 2'd3) state <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (!avm_waitrequest) begin
                  wsum <= wsum + word;
                  if (!last) begin
                     idx   <= idx + 1'b1;
                     state <= S_COLLECT;
                  end else if (VERIFY != 0) begin
                     idx   <= '0;
                     state <= S_RD_REQ;
                  end else begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end
               end
            end
            S_RD_REQ: begin
               if (!avm_waitrequest) state <= S_RD_WAIT;
            end
            S_RD_WAIT: begin
               if (avm_readdatavalid) begin
                  rsum <= rsum_next;
                  if (!last) begin
                     idx   <= idx + 1'b1;
                     state <= S_RD_REQ;
                  end else begin
                     done  <= 1'b1;
                     error <= (rsum_next == wsum) ? ERR_OK : ERR_SUM;
                     state <= S_DONE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: stream source, Avalon memory with random stalls and
// latency, and a word-level reference model of the expected writes, reads and result code.
module tb_imem_loader;
   localparam int AW = 8;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic          start0 = 1'b0, start1 = 1'b0;
   logic [AW:0]   length = '0;
   logic [7:0]    s_data = '0;
   logic          s_valid = 1'b0;
   logic          waitreq = 1'b0;
   logic [31:0]   rdata = '0;
   logic          rdv = 1'b0;

   logic          s_ready0, s_ready1, wr0, wr1, rd0, rd1, busy0, busy1, hold0, hold1, done0, done1;
   logic [AW+1:0] addr0, addr1;
   logic [31:0]   wdata0, wdata1;
   logic [3:0]    be0, be1;
   logic [1:0]    err0, err1;

   imem_loader #(.ADDR_W(AW), .NUM_WORDS(256), .VERIFY(1)) dut_v (
      .clk(clk), .reset_n(reset_n), .start(start0), .length(length),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready0),
      .avm_address(addr0), .avm_write(wr0), .avm_read(rd0), .avm_writedata(wdata0),
      .avm_byteenable(be0), .avm_waitrequest(waitreq), .avm_readdata(rdata),
      .avm_readdatavalid(rdv), .busy(busy0), .cpu_hold(hold0), .done(done0), .error(err0));

   imem_loader #(.ADDR_W(AW), .NUM_WORDS(256), .VERIFY(0)) dut_nv (
      .clk(clk), .reset_n(reset_n), .start(start1), .length(length),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready1),
      .avm_address(addr1), .avm_write(wr1), .avm_read(rd1), .avm_writedata(wdata1),
      .avm_byteenable(be1), .avm_waitrequest(waitreq), .avm_readdata(rdata),
      .avm_readdatavalid(rdv), .busy(busy1), .cpu_hold(hold1), .done(done1), .error(err1));

   logic sel = 1'b0;
   logic          m_sready, m_w, m_r, m_busy, m_hold, m_done;
   logic [AW+1:0] m_addr;
   logic [31:0]   m_wdata;
   logic [3:0]    m_be;
   logic [1:0]    m_err;
   assign m_sready = sel ? s_ready1 : s_ready0;
   assign m_w      = sel ? wr1 : wr0;
   assign m_r      = sel ? rd1 : rd0;
   assign m_busy   = sel ? busy1 : busy0;
   assign m_hold   = sel ? hold1 : hold0;
   assign m_done   = sel ? done1 : done0;
   assign m_addr   = sel ? addr1 : addr0;
   assign m_wdata  = sel ? wdata1 : wdata0;
   assign m_be     = sel ? be1 : be0;
   assign m_err    = sel ? err1 : err0;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", tag, act, exp);
      end
   endtask

   // Bus / stream environment state
   logic [7:0]  q_bytes[$];
   logic [AW+1:0] wq_addr[$];
   logic [31:0] wq_data[$];
   logic [31:0] mem[256];
   logic [31:0] exp_w[256];
   bit gap = 0, stall = 0, flip = 0;
   bit pend = 0;
   int pend_cnt = 0;
   logic [31:0] pend_data = '0;
   int nwrites = 0, nreads = 0;
   int cyc = 0, last_evt = -1, done_cyc = -1;
   bit busy_at_done = 0, busy_before_done = 0, prev_busy = 0;
   bit prev_w = 0, prev_r = 0, prev_wait = 0;
   logic [AW+1:0] prev_addr = '0;
   logic [31:0] prev_data = '0;

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset_n) begin
            waitreq = 1'b0; rdv = 1'b0; s_valid = 1'b0;
            prev_w = 0; prev_r = 0; pend = 0;
         end else begin
            bit wait_now, rdv_n, sv_n;
            chk("no_rd_wr_overlap", 32'(m_w & m_r), 32'd0);
            chk("byteenable", 32'(m_be), (m_w | m_r) ? 32'hF : 32'h0);
            if (m_w | m_r) chk("hold_during_bus", 32'(m_hold), 32'd1);
            if (prev_wait && prev_w) begin
               chk("wstall_write", 32'(m_w), 32'd1);
               chk("wstall_addr", 32'(m_addr), 32'(prev_addr));
               chk("wstall_data", m_wdata, prev_data);
            end
            if (prev_wait && prev_r) begin
               chk("rstall_read", 32'(m_r), 32'd1);
               chk("rstall_addr", 32'(m_addr), 32'(prev_addr));
            end
            if (m_done && done_cyc < 0) begin
               done_cyc = cyc;
               busy_at_done = m_busy;
               busy_before_done = prev_busy;
            end
            wait_now = stall ? ($urandom_range(1, 0) == 1) : 1'b0;
            rdv_n = 1'b0;
            if (pend) begin
               if (pend_cnt == 0) begin
                  rdv_n = 1'b1; rdata = pend_data; pend = 0; last_evt = cyc;
               end else pend_cnt--;
            end
            if (m_w && !wait_now) begin
               wq_addr.push_back(m_addr);
               wq_data.push_back(m_wdata);
               mem[m_addr[AW+1:2]] = m_wdata;
               nwrites++;
               last_evt = cyc;
            end
            if (m_r && !wait_now) begin
               nreads++;
               pend = 1;
               pend_cnt = $urandom_range(2, 0);
               pend_data = mem[m_addr[AW+1:2]] ^ ((flip && m_addr[AW+1:2] == 3) ? 32'd1 : 32'd0);
            end
            sv_n = 1'b0;
            if (q_bytes.size() > 0 && (!gap || $urandom_range(1, 0) == 1)) begin
               sv_n = 1'b1;
               s_data = q_bytes[0];
            end
            if (sv_n && m_sready) void'(q_bytes.pop_front());
            prev_w = m_w; prev_r = m_r; prev_addr = m_addr; prev_data = m_wdata;
            prev_wait = wait_now; prev_busy = m_busy;
            waitreq = wait_now; rdv = rdv_n; s_valid = sv_n;
         end
      end
   end

   task automatic pulse_start(input int len, input bit vsel);
      length = len[AW:0];
      if (vsel) start1 = 1'b1; else start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
   endtask

   task automatic run_load(input int len, input bit vsel, input bit seq, input bit gap_i,
                           input bit stall_i, input bit flip_i, input bit poke);
      bit valid_len;
      logic [31:0] ws, rs;
      logic [1:0] exp_err;
      int exp_reads;
      valid_len = (len >= 1) && (len <= 256);
      @(negedge clk);
      sel = vsel; gap = gap_i; stall = stall_i; flip = flip_i;
      nwrites = 0; nreads = 0; done_cyc = -1; last_evt = -1;
      wq_addr.delete(); wq_data.delete(); q_bytes.delete();
      ws = '0; rs = '0;
      if (valid_len) begin
         for (int i = 0; i < len; i++) begin
            logic [7:0] b[4];
            for (int k = 0; k < 4; k++) begin
               b[k] = seq ? 8'(4 * i + k + 1) : 8'($urandom);
               q_bytes.push_back(b[k]);
            end
            exp_w[i] = {b[3], b[2], b[1], b[0]};
            ws += exp_w[i];
            rs += (flip_i && i == 3) ? (exp_w[i] ^ 32'd1) : exp_w[i];
         end
      end
      exp_err = !valid_len ? 2'b01 : (vsel ? 2'b00 : ((ws == rs) ? 2'b00 : 2'b10));
      exp_reads = (valid_len && !vsel) ? len : 0;
      pulse_start(len, vsel);
      if (valid_len) begin
         chk("busy_after_start", 32'(m_busy), 32'd1);
         chk("hold_after_start", 32'(m_hold), 32'd1);
         chk("sready_after_start", 32'(m_sready), 32'd1);
         chk("done_cleared", 32'(m_done), 32'd0);
      end else begin
         chk("badlen_busy", 32'(m_busy), 32'd0);
         chk("badlen_done", 32'(m_done), 32'd1);
      end
      for (int c = 0; c < 20000 && !m_done; c++) begin
         @(negedge clk);
         if (poke && c == 20) begin
            length = 9'd5;
            if (vsel) start1 = 1'b1; else start0 = 1'b1;
         end
         if (poke && c == 21) begin
            start0 = 1'b0; start1 = 1'b0;
         end
      end
      start0 = 1'b0; start1 = 1'b0;
      chk("done_within_bound", 32'(m_done), 32'd1);
      @(negedge clk);
      chk("error_code", 32'(m_err), 32'(exp_err));
      chk("write_count", nwrites, valid_len ? len : 0);
      chk("read_count", nreads, exp_reads);
      chk("busy_after_done", 32'(m_busy), 32'd0);
      chk("hold_after_done", 32'(m_hold), 32'd0);
      if (valid_len) begin
         chk("done_one_after_last", done_cyc, last_evt + 1);
         chk("busy_falls_with_done", 32'(busy_at_done), 32'd0);
         chk("busy_before_done", 32'(busy_before_done), 32'd1);
         for (int i = 0; i < len && i < wq_addr.size(); i++) begin
            chk($sformatf("waddr[%0d]", i), 32'(wq_addr[i]), 32'(i * 4));
            chk($sformatf("wdata[%0d]", i), wq_data[i], exp_w[i]);
         end
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_sready", 32'(s_ready0), 32'd0);
      chk("rst_write", 32'(wr0), 32'd0);
      chk("rst_read", 32'(rd0), 32'd0);
      chk("rst_addr", 32'(addr0), 32'd0);
      chk("rst_wdata", wdata0, 32'd0);
      chk("rst_be", 32'(be0), 32'd0);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_hold", 32'(hold0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("rst_error", 32'(err0), 32'd0);

      run_load(2, 0, 1, 0, 0, 0, 0);
      chk("seq_word0", wq_data.size() > 0 ? wq_data[0] : 32'hDEAD, 32'h04030201);
      run_load(16, 0, 0, 1, 1, 0, 1);
      run_load(0, 0, 0, 0, 0, 0, 0);
      run_load(257, 0, 0, 0, 0, 0, 0);
      run_load(8, 0, 0, 1, 1, 1, 0);
      run_load(256, 1, 0, 1, 1, 0, 0);
      chk("last_write_addr", wq_addr.size() > 0 ? 32'(wq_addr[$]) : 32'hDEAD, 32'h3FC);
      for (int t = 0; t < 4; t++)
         run_load($urandom_range(12, 1), 1'($urandom_range(1, 0)), 0,
                  1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 0, 0);

      // Reset in the middle of a write
      @(negedge clk);
      sel = 0; stall = 1; gap = 0; flip = 0;
      q_bytes.delete();
      for (int i = 0; i < 16; i++) q_bytes.push_back(8'($urandom));
      pulse_start(4, 0);
      for (int c = 0; c < 200 && !wr0; c++) @(negedge clk);
      chk("reached_write", 32'(wr0), 32'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("rst_mid_write", 32'(wr0), 32'd0);
      chk("rst_mid_read", 32'(rd0), 32'd0);
      chk("rst_mid_busy", 32'(busy0), 32'd0);
      chk("rst_mid_done", 32'(done0), 32'd0);
      @(negedge clk);
      q_bytes.delete();
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle_after_rst_busy", 32'(busy0), 32'd0);
      chk("idle_after_rst_done", 32'(done0), 32'd0);
      run_load(4, 0, 0, 1, 1, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Avalon-MM master that fills a processor's 256×32 on-chip instruction memory from an 8-bit valid/ready byte stream, such as a UART receiver or JTAG bridge. It holds the attached processor in reset while loading. It assembles bytes little-endian into 32-bit words and writes them to consecutive word addresses. It then optionally reads every written word back and compares a running 32-bit sum to confirm the load.

## Interface
Parameters:
- ADDR_W, 8: instruction-memory word-address width.
- NUM_WORDS, 256: memory depth in words; maximum legal load length.
- VERIFY, 1: 1 = read-back checksum pass after writing; 0 = skip it.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- length  in  ADDR_W+1  number of words to load; latched on an accepted start.
- s_data  in  8  stream byte.
- s_valid  in  1  stream byte valid.
- s_ready  out  1  loader accepts s_data this cycle.
- avm_address  out  ADDR_W+2  byte address = word index × 4; bits [1:0] always 0.
- avm_write  out  1  Avalon write request.
- avm_read  out  1  Avalon read request.
- avm_writedata  out  32  assembled word.
- avm_byteenable  out  4  constant 4'b1111 whenever write or read is asserted, else 0.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  read-back data.
- avm_readdatavalid  in  1  read-back data valid.
- busy  out  1  high from an accepted start until DONE.
- cpu_hold  out  1  reset request to the processor; equals busy.
- done  out  1  level; set on completion, cleared by the next accepted start.
- error  out  2  result code; valid when done=1. 00 = ok, 01 = bad length, 10 = checksum mismatch.

## Operation
- FSM states:
  - IDLE
  - COLLECT: gathering bytes into a word.
  - WRITE: Avalon write in progress.
  - RD_REQ: Avalon read request in progress.
  - RD_WAIT: waiting for read data.
  - DONE
- Accepting a start:
  - IDLE + start=1 latches length and clears done, error, the word index, byte count, write sum and read sum.
  - If length==0 or length>NUM_WORDS: go to DONE with error=01 and perform no bus access.
  - Otherwise go to COLLECT.
  - start outside IDLE is ignored; DONE counts as IDLE for start purposes.
- COLLECT:
  - s_ready=1.
  - Each s_valid&s_ready byte k (k=0..3) goes into bits [8k+7:8k] of the word.
  - Acceptance of byte 3 moves the FSM to WRITE.
- WRITE:
  - avm_write=1, with address and data held stable until the cycle where avm_waitrequest=0; that cycle completes the write.
  - On completion: wsum += word (modulo 2^32) and the index increments.
  - If index == length-1, go to RD_REQ (VERIFY=1) or DONE (VERIFY=0); otherwise go to COLLECT.
- RD_REQ:
  - avm_read=1, held until avm_waitrequest=0, then go to RD_WAIT.
  - The index restarts at 0 for this pass.
  - At most one read is outstanding.
- RD_WAIT:
  - On avm_readdatavalid: rsum += avm_readdata.
  - Then either issue the next read (back to RD_REQ) or, after the last word, compare sums: equal gives error=00, unequal gives error=10. Go to DONE.
- DONE: busy=0, done=1. Behaves as IDLE.
- Stray avm_readdatavalid outside RD_WAIT is ignored.
- Indexing: word index runs 0..length-1. A length of NUM_WORDS reaches the last address (0x3FC for defaults); the index never wraps within a load.

## Timing
- Reset values:
  - All outputs 0.
  - FSM in IDLE; all internal counters and sums cleared.
- Asynchronous reset mid-load:
  - Avalon strobes drop immediately and the FSM returns to IDLE.
  - Memory contents are undefined.
  - done stays 0 until a new load finishes.
- Handshakes:
  - busy and cpu_hold rise the cycle after an accepted start; s_ready rises in that same cycle.
  - s_ready drops the cycle after byte 3 is accepted. avm_write is asserted in that same cycle, with no bubble.
  - With waitrequest=0, each write occupies exactly 1 cycle in WRITE. The next byte can be accepted on the following cycle.
  - Reads: 1 cycle in RD_REQ plus slave latency in RD_WAIT. The next read is issued the cycle after readdatavalid.
- Completion:
  - done rises the cycle after the final write completes (VERIFY=0) or after the final readdatavalid (VERIFY=1).
  - busy and cpu_hold fall in the same cycle done rises.
- avm_write and avm_read are never asserted together.

## Test plan
- Load with verify: length=2, bytes 01 02 03 04 05 06 07 08. Expected:
  - Writes 0x04030201 @0x000 and 0x08070605 @0x004.
  - Two reads follow.
  - done=1, error=00.
  - cpu_hold is high for the whole load.
- Wait-state stress: waitrequest random at 50% on a 16-word load. Expected:
  - Every write/read has stable address/data while stalled.
  - Exactly 16 writes and 16 reads.
  - error=00.
- Bad lengths: length=0 -> done=1, error=01, no bus strobe; same for length=257.
- Verify failure: memory model flips bit 0 of word 3 on read-back. Expected: error=10.
- Full depth with stalls: length=256, VERIFY=0, s_valid gapped. Expected:
  - Last write at 0x3FC.
  - No read strobes.
  - done one cycle after the last write completes.
- Robustness:
  - start pulsed while busy -> ignored.
  - reset_n low mid-WRITE -> strobes 0 immediately, IDLE afterward, next load succeeds.
